// File: rtl/spi_bitrev_pkg.sv
// Shared types and helpers for the bit-reverse SPI slave.
package spi_bitrev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_TX   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Returns 1 when data is sampled on the rising sck edge, 0 when on the falling edge.
    function automatic logic sample_on_rise(input int unsigned cpol, input int unsigned cpha);
        return (cpol != 0) == (cpha != 0);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronisers for sck/ss/mosi plus sck rise/fall pulses.
module spi_edge_sync #(
    parameter logic SCK_IDLE = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_sync,
    output logic mosi_sync
);

    logic [2:0] sck_pipe_q, sck_pipe_d;
    logic [1:0] ss_pipe_q, ss_pipe_d;
    logic [1:0] mosi_pipe_q, mosi_pipe_d;

    always_comb begin
        sck_pipe_d  = {sck_pipe_q[1:0], sck};
        ss_pipe_d   = {ss_pipe_q[0], ss};
        mosi_pipe_d = {mosi_pipe_q[0], mosi};
    end

    // Reset to the idle line levels so leaving reset never fakes an edge or a select.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_pipe_q  <= {3{SCK_IDLE}};
            ss_pipe_q   <= '1;
            mosi_pipe_q <= '0;
        end else begin
            sck_pipe_q  <= sck_pipe_d;
            ss_pipe_q   <= ss_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
        end
    end

    assign sck_rise  = sck_pipe_q[1] & ~sck_pipe_q[2];
    assign sck_fall  = ~sck_pipe_q[1] & sck_pipe_q[2];
    assign ss_sync   = ss_pipe_q[1];
    assign mosi_sync = mosi_pipe_q[1];

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI slave: receives a word MSB-first, returns it bit-reversed in the same transaction.
// Build option SPI_BITREV_MULTI_EN accepts back-to-back words within one ss-low transaction.
module spi_bitrev_slave
    import spi_bitrev_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CPOL   = 0,
    parameter int unsigned CPHA   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned     CNT_W       = $clog2(DATA_W + 1);
    localparam logic            SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);

    logic sck_rise, sck_fall, ss_sync, mosi_sync;
    logic sample_edge, shift_edge;

    spi_edge_sync #(
        .SCK_IDLE (CPOL != 0)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .sck       (sck),
        .ss        (ss),
        .mosi      (mosi),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .ss_sync   (ss_sync),
        .mosi_sync (mosi_sync)
    );

    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              miso_q, miso_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] assembled;

    assign assembled = {sh_q[DATA_W-2:0], mosi_sync};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        tx_sh_d      = tx_sh_q;
        rx_data_d    = rx_data_q;
        miso_d       = miso_q;
        frame_done_d = 1'b0;

        // Deselect overrides everything, including a coincident sample edge.
        if (ss_sync) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            tx_sh_d = '0;
            miso_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    miso_d  = 1'b1;
                    state_d = ST_RX;
                end
                ST_RX: begin
                    miso_d = 1'b1;
                    if (sample_edge) begin
                        sh_d = assembled;
                        if (cnt_q == LAST_BIT) begin
                            rx_data_d = assembled;
                            tx_sh_d   = assembled;
                            cnt_d     = '0;
                            state_d   = ST_TX;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_TX: begin
                    if (shift_edge) begin
                        miso_d  = tx_sh_q[0];
                        tx_sh_d = {1'b0, tx_sh_q[DATA_W-1:1]};
                    end
                    if (sample_edge) begin
                        if (cnt_q == LAST_BIT) begin
                            frame_done_d = 1'b1;
                            cnt_d        = '0;
                            miso_d       = 1'b1;
`ifdef SPI_BITREV_MULTI_EN
                            sh_d         = '0;
                            state_d      = ST_RX;
`else
                            state_d      = ST_DONE;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    miso_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    miso_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            tx_sh_q      <= '0;
            rx_data_q    <= '0;
            miso_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            tx_sh_q      <= tx_sh_d;
            rx_data_q    <= rx_data_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign miso       = miso_q;
    assign rx_data    = rx_data_q;
    assign frame_done = frame_done_q;
    assign busy       = ((state_q == ST_RX) || (state_q == ST_TX)) && !ss_sync;

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Scoreboard bench: three slaves (mode 0/8b, mode 3/8b, mode 1/16b) driven by a bit-banged master.
module tb_spi_bitrev_slave;

    localparam time HALF = 80ns;

    logic clk;
    logic reset;
    logic sck  [3];
    logic ss   [3];
    logic mosi [3];
    logic miso_w [3];
    logic fd_w   [3];
    logic busy_w [3];
    logic [7:0]  rx0, rx1;
    logic [15:0] rx2;

    int n_cmp;
    int n_err;

    logic [31:0] rd_q [$];
    logic [31:0] fdq0 [$];
    logic [31:0] fdq1 [$];
    logic [31:0] fdq2 [$];

    initial clk = 1'b0;
    always #5ns clk = ~clk;

    spi_bitrev_slave #(.DATA_W(8), .CPOL(0), .CPHA(0)) u_m0 (
        .clock(clk), .reset(reset), .sck(sck[0]), .ss(ss[0]), .mosi(mosi[0]),
        .miso(miso_w[0]), .rx_data(rx0), .frame_done(fd_w[0]), .busy(busy_w[0])
    );
    spi_bitrev_slave #(.DATA_W(8), .CPOL(1), .CPHA(1)) u_m3 (
        .clock(clk), .reset(reset), .sck(sck[1]), .ss(ss[1]), .mosi(mosi[1]),
        .miso(miso_w[1]), .rx_data(rx1), .frame_done(fd_w[1]), .busy(busy_w[1])
    );
    spi_bitrev_slave #(.DATA_W(16), .CPOL(0), .CPHA(1)) u_m1w16 (
        .clock(clk), .reset(reset), .sck(sck[2]), .ss(ss[2]), .mosi(mosi[2]),
        .miso(miso_w[2]), .rx_data(rx2), .frame_done(fd_w[2]), .busy(busy_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[n-1-i] = v[i];
        return r;
    endfunction

    // Master view of a single-word frame: all ones during RX, then the reversed word.
    function automatic logic [31:0] exp_single(input logic [31:0] w, input int n);
        logic [31:0] e;
        e = bitrev(w, n);
        for (int i = 0; i < n; i++) e[2*n-1-i] = 1'b1;
        return e;
    endfunction

    function automatic logic cpol_of(input int d);
        return d == 1;
    endfunction

    function automatic logic cpha_of(input int d);
        return d != 0;
    endfunction

    function automatic int fdq_size(input int d);
        case (d)
            0:       return fdq0.size();
            1:       return fdq1.size();
            default: return fdq2.size();
        endcase
    endfunction

    task automatic fdq_push(input int d, input logic [31:0] v);
        case (d)
            0:       fdq0.push_back(v);
            1:       fdq1.push_back(v);
            default: fdq2.push_back(v);
        endcase
    endtask

    always @(negedge clk) begin
        if (fd_w[0]) begin
            if (fdq0.size() == 0) chk("fd0_unexpected", 32'd1, 32'd0);
            else chk("fd0_rx_data", {24'b0, rx0}, fdq0.pop_front());
        end
    end
    always @(negedge clk) begin
        if (fd_w[1]) begin
            if (fdq1.size() == 0) chk("fd1_unexpected", 32'd1, 32'd0);
            else chk("fd1_rx_data", {24'b0, rx1}, fdq1.pop_front());
        end
    end
    always @(negedge clk) begin
        if (fd_w[2]) begin
            if (fdq2.size() == 0) chk("fd2_unexpected", 32'd1, 32'd0);
            else chk("fd2_rx_data", {16'b0, rx2}, fdq2.pop_front());
        end
    end

    task automatic xfer(input int d, input int nbits, input logic [31:0] tx, output logic [31:0] rx);
        logic cpol, cpha;
        cpol = cpol_of(d);
        cpha = cpha_of(d);
        rx = '0;
        @(negedge clk);
        #2ns;
        ss[d] = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[d] = tx[nbits-1-i];
                #HALF;
                sck[d] = ~cpol;
                rx = {rx[30:0], miso_w[d]};
                #HALF;
                sck[d] = cpol;
            end else begin
                sck[d] = ~cpol;
                mosi[d] = tx[nbits-1-i];
                #HALF;
                sck[d] = cpol;
                rx = {rx[30:0], miso_w[d]};
                #HALF;
            end
        end
        #HALF;
        ss[d] = 1'b1;
        #HALF;
        #HALF;
    endtask

    task automatic run_frame(input string tag, input int d, input int n, input logic [31:0] w);
        logic [31:0] got;
        rd_q.push_back(exp_single(w, n));
        fdq_push(d, w);
        xfer(d, 2 * n, w << n, got);
        chk(tag, got, rd_q.pop_front());
        chk({tag, "_fd_missing"}, 32'(fdq_size(d)), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] rst_got;
        logic [7:0]  second;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            sck[d]  = cpol_of(d);
            ss[d]   = 1'b1;
            mosi[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < 3; d++) begin
            chk("rst_miso", {31'b0, miso_w[d]}, 32'd1);
            chk("rst_fd",   {31'b0, fd_w[d]},   32'd0);
            chk("rst_busy", {31'b0, busy_w[d]}, 32'd0);
        end
        chk("rst_rx0", {24'b0, rx0}, 32'd0);
        chk("rst_rx1", {24'b0, rx1}, 32'd0);
        chk("rst_rx2", {16'b0, rx2}, 32'd0);

        run_frame("m0_b4", 0, 8, 32'hB4);
        chk("m0_b4_rx", {24'b0, rx0}, 32'hB4);
        chk("m0_b4_rev", exp_single(32'hB4, 8) & 32'hFF, 32'h2D);

        run_frame("m3_01", 1, 8, 32'h01);
        run_frame("m3_80", 1, 8, 32'h80);
        chk("m3_rx", {24'b0, rx1}, 32'h80);

        run_frame("m1_1234", 2, 16, 32'h1234);
        chk("m1_rx", {16'b0, rx2}, 32'h1234);

        run_frame("m0_0f", 0, 8, 32'h0F);
        xfer(0, 3, 32'h5, got);
        chk("abort_miso", got, 32'h7);
        chk("abort_rx_kept", {24'b0, rx0}, 32'h0F);
        chk("abort_busy", {31'b0, busy_w[0]}, 32'd0);
        run_frame("m0_after_abort", 0, 8, 32'hB4);
        chk("after_abort_rx", {24'b0, rx0}, 32'hB4);

`ifdef SPI_BITREV_MULTI_EN
        second = bitrev(32'hB4, 8) & 8'hFF;
        fdq_push(0, 32'h01);
        fdq_push(0, 32'hB4);
`else
        second = 8'hFF;
        fdq_push(0, 32'h01);
`endif
        rd_q.push_back({8'hFF, 8'h80, 8'hFF, second});
        xfer(0, 32, {8'h01, 8'h00, 8'hB4, 8'h00}, got);
        chk("multi_read", got, rd_q.pop_front());
        chk("multi_fd_missing", 32'(fdq_size(0)), 32'd0);
`ifdef SPI_BITREV_MULTI_EN
        chk("multi_rx", {24'b0, rx0}, 32'hB4);
`else
        chk("multi_rx", {24'b0, rx0}, 32'h01);
`endif

        fork
            xfer(0, 16, 32'hC300, rst_got);
            begin
                repeat (200) @(posedge clk);
                @(negedge clk);
                chk("tx_busy", {31'b0, busy_w[0]}, 32'd1);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("midtx_rst_miso", {31'b0, miso_w[0]}, 32'd1);
                chk("midtx_rst_busy", {31'b0, busy_w[0]}, 32'd0);
                chk("midtx_rst_rx",   {24'b0, rx0},       32'd0);
                @(negedge clk);
                chk("midtx_idle_busy", {31'b0, busy_w[0]}, 32'd0);
            end
        join
        chk("post_rst_rx", {24'b0, rx0}, 32'd0);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
